namuru_multi_time_base: RTL
===========================

// Module: namuru_multi_time_base
// PURPOSE
//  Parametrised time base for the namuru correlator: one TIC generator plus NACC independent
//  accumulation-interrupt generators, all single-cycle enables in the clk domain.
//  Adds shadowed divide registers (glitch-free period change), configurable preTIC-to-TIC lead,
//  a run/freeze control, per-channel accum-to-TIC phase resync and a TIC epoch counter.
//  Feeds code_nco (pre_tic_enable), code_gen/latches (tic_enable) and the accum IRQ logic.
// PARAMETERS
//  CW       24  width of all down-counters and divide values
//  NACC     2   number of accumulation-interrupt channels (>=1)
//  PRE_LEAD 1   clk cycles from pre_tic_enable to tic_enable (>=1)
//  EPOCH_W  16  width of TIC epoch counter
// PORTS
//  clk            in   1          system clock
//  rstn           in   1          reset, synchronous, active-low
//  run            in   1          1 = count; 0 = freeze all state, force all enables low
//  div_load       in   1          strobe: capture tic_divide/accum_divide into shadow registers
//  tic_divide     in   CW         TIC period minus 1, in clk cycles
//  accum_divide   in   NACC*CW    per-channel accum period minus 1; channel i = [i*CW +: CW]
//  accum_tic_sync in   NACC       per-channel: 1 = reload accum counter on every pre_tic pulse
//  pre_tic_enable out  1          1-cycle pulse at TIC counter terminal count
//  tic_enable     out  1          pre_tic_enable delayed PRE_LEAD cycles
//  accum_enable   out  NACC       1-cycle pulse per channel at terminal count
//  tic_count      out  CW         live TIC counter value
//  accum_count    out  NACC*CW    live accum counter values, same packing as accum_divide
//  tic_epoch      out  EPOCH_W    number of tic_enable pulses since reset, modulo 2^EPOCH_W
// BEHAVIOUR
//  Reset (rstn=0 at posedge): all counters and shadows = all-ones; PRE_LEAD delay line = 0;
//   tic_epoch = 0; so pre_tic_enable, tic_enable, accum_enable = 0. Reset overrides all inputs.
//  Shadows: on div_load & rstn, shadow_tic <= tic_divide, shadow_acc[i] <= accum_divide[i]
//   (independent of run). Counters reload only from shadows, never from ports directly.
//  TIC counter, priority per posedge: reset > !run (hold) > tic_q==0 (load shadow_tic) > tic_q-1.
//   pre_tic_enable = run & (tic_q==0), combinational. Period = shadow_tic+1 cycles.
//   shadow_tic==0 -> pre_tic_enable high every run cycle.
//  Reload vs div_load same edge: reload uses the shadow value held BEFORE that edge; the new
//   value governs the following period. Mid-period div_load never alters the current period.
//  tic_enable: PRE_LEAD-stage shift register fed by pre_tic_enable, advances only when run=1;
//   tic_enable = run & last stage. Freeze holds in-flight pulses; they emerge after run returns.
//  Accum channel i, priority: reset > !run (hold) > (acc_q==0) or (accum_tic_sync[i] &
//   pre_tic_enable) (load shadow_acc[i]) > acc_q-1. accum_enable[i] = run & (acc_q==0).
//   Sync reload does not itself raise accum_enable; a channel at zero on a sync edge pulses once.
//   With sync set and shadow_acc >= shadow_tic, accum pulses only if a phase hits zero first.
//  tic_epoch increments (wraps at 2^EPOCH_W-1 -> 0) on each cycle tic_enable=1.
//  No counter ever underflows: zero always reloads. All arithmetic unsigned, CW-bit.
//  Outputs are combinational from registers only (no input-to-output path except via run gating).
// TESTING
//  T1 reset, div_load tic_divide=4, wait: first pre_tic after 2^CW cycles, then every 5 cycles;
//     tic_enable exactly PRE_LEAD cycles later; tic_epoch counts 1,2,3...
//  T2 tic_divide=0 loaded: pre_tic_enable continuously high while run=1; tic_epoch +1 per cycle.
//  T3 period 9, div_load tic_divide=3 at count 5: remaining period unchanged (pulse at 0),
//     next periods = 4; repeat with div_load on the terminal-count edge -> one more 10-cycle period.
//  T4 run=0 for 7 cycles at tic_q=2 with PRE_LEAD=3 pulse in flight: all enables 0, counts frozen;
//     on resume pre_tic after 2 cycles, held tic_enable emerges at remaining delay.
//  T5 NACC=2, accum_divide={7,3}, accum_tic_sync=2'b10, tic_divide=15: ch0 pulses every 4,
//     ch1 reloads on each pre_tic so its pulses sit at fixed offset 8 after each pre_tic.
//  T6 reset asserted mid-period and mid-delay-line: next cycle all outputs 0, counts all-ones,
//     epoch 0; EPOCH_W=4 wrap 15 -> 0 checked.

Source files
------------

// File: rtl/namuru_multi_time_base_if.sv
// -----------------------------------------------------------------------------
// namuru_multi_time_base_if
//
// Bundles the control inputs and the enable/counter outputs of the namuru
// multi-channel time base.
//
//   master modport : drives run/div_load/divides/sync, observes enables/counts
//   slave  modport : the time base itself
//
// Signals
//   run            1 = count; 0 = freeze all state and force enables low
//   div_load       strobe: capture tic_divide/accum_divide into shadows
//   tic_divide     TIC period minus 1, in clk cycles
//   accum_divide   per-channel accum period minus 1, channel i = [i*CW +: CW]
//   accum_tic_sync per-channel: reload accum counter on every pre_tic pulse
//   pre_tic_enable 1-cycle pulse at TIC terminal count
//   tic_enable     pre_tic_enable delayed PRE_LEAD run cycles
//   accum_enable   1-cycle pulse per channel at terminal count
//   tic_count      live TIC counter value
//   accum_count    live accum counter values, same packing as accum_divide
//   tic_epoch      tic_enable pulses since reset, modulo 2^EPOCH_W
// -----------------------------------------------------------------------------
interface namuru_multi_time_base_if #(
    parameter int CW      = 24,
    parameter int NACC    = 2,
    parameter int EPOCH_W = 16
);
    logic                 run;
    logic                 div_load;
    logic [CW-1:0]        tic_divide;
    logic [NACC*CW-1:0]   accum_divide;
    logic [NACC-1:0]      accum_tic_sync;

    logic                 pre_tic_enable;
    logic                 tic_enable;
    logic [NACC-1:0]      accum_enable;
    logic [CW-1:0]        tic_count;
    logic [NACC*CW-1:0]   accum_count;
    logic [EPOCH_W-1:0]   tic_epoch;

    modport master (
        output run, div_load, tic_divide, accum_divide, accum_tic_sync,
        input  pre_tic_enable, tic_enable, accum_enable, tic_count,
               accum_count, tic_epoch
    );

    modport slave (
        input  run, div_load, tic_divide, accum_divide, accum_tic_sync,
        output pre_tic_enable, tic_enable, accum_enable, tic_count,
               accum_count, tic_epoch
    );
endinterface

// File: rtl/namuru_multi_time_base.sv
// -----------------------------------------------------------------------------
// namuru_multi_time_base
//
// Time base for the namuru correlator: one TIC generator plus NACC independent
// accumulation-interrupt generators. All enables are single-cycle pulses in
// the clk domain.
//
//   - Divide values are captured into shadow registers on div_load; counters
//     only ever reload from the shadows, so a period change always takes
//     effect on a period boundary and never truncates a running period.
//   - pre_tic_enable fires at TIC terminal count; tic_enable follows it after
//     PRE_LEAD run cycles (the delay line freezes with run=0).
//   - Each accum channel can optionally be re-phased to the TIC by reloading
//     on every pre_tic pulse (accum_tic_sync).
//   - tic_epoch counts tic_enable pulses.
//
// Ports
//   clk   system clock
//   rstn  synchronous, active-low reset
//   mtb   slave side of namuru_multi_time_base_if (controls in, enables and
//         live counter values out)
//
// Parameters
//   CW        width of all down-counters and divide values
//   NACC      number of accumulation channels (>=1)
//   PRE_LEAD  clk cycles from pre_tic_enable to tic_enable (>=1)
//   EPOCH_W   width of the TIC epoch counter
// -----------------------------------------------------------------------------
module namuru_multi_time_base #(
    parameter int CW       = 24,
    parameter int NACC     = 2,
    parameter int PRE_LEAD = 1,
    parameter int EPOCH_W  = 16
) (
    input  logic                      clk,
    input  logic                      rstn,
    namuru_multi_time_base_if.slave   mtb
);

    localparam logic [CW-1:0]      CNT_ONE   = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [EPOCH_W-1:0] EPOCH_ONE = {{(EPOCH_W-1){1'b0}}, 1'b1};

    // ------------------------------------------------------------------
    // TIC generator
    // ------------------------------------------------------------------
    logic [CW-1:0]       shadow_tic_reg;
    logic [CW-1:0]       tic_q_reg;
    logic [PRE_LEAD-1:0] dly_reg;
    logic [EPOCH_W-1:0]  epoch_reg;
    logic                pre_tic;
    logic                tic_en;

    // Enables are gated by run so a freeze drops them in the same cycle,
    // while the registered state behind them is simply held.
    assign pre_tic = mtb.run & (tic_q_reg == '0);
    assign tic_en  = mtb.run & dly_reg[PRE_LEAD-1];

    // Shadow capture is independent of run so software can retune while
    // the time base is frozen.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            shadow_tic_reg <= '1;
        end else if (mtb.div_load) begin
            shadow_tic_reg <= mtb.tic_divide;
        end
    end

    // Reload samples the shadow as it stood before this edge, so a div_load
    // on the terminal-count edge governs the period after next.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            tic_q_reg <= '1;
        end else if (mtb.run) begin
            if (tic_q_reg == '0) begin
                tic_q_reg <= shadow_tic_reg;
            end else begin
                tic_q_reg <= tic_q_reg - CNT_ONE;
            end
        end
    end

    // preTIC-to-TIC delay line; advances only while running so pulses in
    // flight during a freeze emerge later with their remaining delay.
    generate
        if (PRE_LEAD == 1) begin : g_dly_single
            always_ff @(posedge clk) begin
                if (!rstn) begin
                    dly_reg <= '0;
                end else if (mtb.run) begin
                    dly_reg <= pre_tic;
                end
            end
        end else begin : g_dly_multi
            always_ff @(posedge clk) begin
                if (!rstn) begin
                    dly_reg <= '0;
                end else if (mtb.run) begin
                    dly_reg <= {dly_reg[PRE_LEAD-2:0], pre_tic};
                end
            end
        end
    endgenerate

    // Epoch wraps naturally at 2^EPOCH_W.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            epoch_reg <= '0;
        end else if (tic_en) begin
            epoch_reg <= epoch_reg + EPOCH_ONE;
        end
    end

    // ------------------------------------------------------------------
    // Accumulation-interrupt channels
    // ------------------------------------------------------------------
    logic [NACC-1:0]    acc_en_vec;
    logic [NACC*CW-1:0] acc_cnt_vec;

    genvar gi;
    generate
        for (gi = 0; gi < NACC; gi++) begin : g_acc
            logic [CW-1:0] shadow_acc_reg;
            logic [CW-1:0] acc_q_reg;
            logic          acc_zero;
            logic          acc_reload;

            assign acc_zero = (acc_q_reg == '0);
            // A sync reload re-phases the channel to the TIC but does not
            // pulse by itself; only reaching zero raises accum_enable.
            assign acc_reload = acc_zero | (mtb.accum_tic_sync[gi] & pre_tic);

            always_ff @(posedge clk) begin
                if (!rstn) begin
                    shadow_acc_reg <= '1;
                end else if (mtb.div_load) begin
                    shadow_acc_reg <= mtb.accum_divide[gi*CW +: CW];
                end
            end

            always_ff @(posedge clk) begin
                if (!rstn) begin
                    acc_q_reg <= '1;
                end else if (mtb.run) begin
                    if (acc_reload) begin
                        acc_q_reg <= shadow_acc_reg;
                    end else begin
                        acc_q_reg <= acc_q_reg - CNT_ONE;
                    end
                end
            end

            assign acc_en_vec[gi]           = mtb.run & acc_zero;
            assign acc_cnt_vec[gi*CW +: CW] = acc_q_reg;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign mtb.pre_tic_enable = pre_tic;
    assign mtb.tic_enable     = tic_en;
    assign mtb.accum_enable   = acc_en_vec;
    assign mtb.tic_count      = tic_q_reg;
    assign mtb.accum_count    = acc_cnt_vec;
    assign mtb.tic_epoch      = epoch_reg;

endmodule
